// File: rtl/mem_pkg.sv
// mem_pkg: mem-op codes, access sizes, FSM states and op decode helpers
package mem_pkg;
    localparam logic [3:0] MEMOP_NONE = 4'd0, MEMOP_LB = 4'd1, MEMOP_LBU = 4'd2, MEMOP_LH = 4'd3,
                           MEMOP_LHU = 4'd4, MEMOP_LW = 4'd5, MEMOP_LWU = 4'd6, MEMOP_LD = 4'd7,
                           MEMOP_SB = 4'd8, MEMOP_SH = 4'd9, MEMOP_SW = 4'd10, MEMOP_SD = 4'd11;
    localparam logic [2:0] SIZE_B = 3'd0, SIZE_H = 3'd1, SIZE_W = 3'd2, SIZE_D = 3'd3;
    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;
    function automatic logic is_load(input logic [3:0] op);
        return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW, MEMOP_LWU, MEMOP_LD};
    endfunction
    function automatic logic is_store(input logic [3:0] op);
        return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SD};
    endfunction
    function automatic logic is_signed(input logic [3:0] op);
        return op inside {MEMOP_LB, MEMOP_LH, MEMOP_LW};
    endfunction
    function automatic logic [2:0] op_size(input logic [3:0] op);
        return (op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH}) ? SIZE_H :
               (op inside {MEMOP_LW, MEMOP_LWU, MEMOP_SW}) ? SIZE_W :
               (op inside {MEMOP_LD, MEMOP_SD}) ? SIZE_D : SIZE_B;
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: misalignment check, store lane replication and strobes, load lane extract/extend
module mem_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int OFF_W  = $clog2(STRB_W)
) (
    input  logic [3:0]        op,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        lop,
    input  logic [OFF_W-1:0]  loff,
    input  logic [DATA_W-1:0] rdata,
    output logic              misal,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata_ext
);
    logic [2:0]        sz, lsz;
    logic [OFF_W-1:0]  amask;
    logic [STRB_W-1:0] span;
    logic [DATA_W-1:0] lane;
    logic              sx;
    always_comb begin
        sz        = op_size(op);
        amask     = OFF_W'((4'd1 << sz) - 4'd1);
        misal     = |(off & amask);
        span      = STRB_W'((9'd1 << (4'd1 << sz)) - 9'd1);
        wstrb     = span << off;
        wdata_rep = sz == SIZE_B ? {STRB_W{wdata[7:0]}} :
                    sz == SIZE_H ? {(STRB_W/2){wdata[15:0]}} :
                    sz == SIZE_W ? {(STRB_W/4){wdata[31:0]}} : wdata;
        lsz       = op_size(lop);
        sx        = is_signed(lop);
        lane      = rdata >> {loff, 3'b000};
        rdata_ext = lsz == SIZE_B ? DATA_W'({{56{sx & lane[7]}}, lane[7:0]}) :
                    lsz == SIZE_H ? DATA_W'({{48{sx & lane[15]}}, lane[15:0]}) :
                    lsz == SIZE_W ? DATA_W'({{32{sx & lane[31]}}, lane[31:0]}) : lane;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit driving a req/addr_ok/data_ok data bus
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int OFF_W  = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_valid,
    input  logic [3:0]        m_op,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_allowin,
    input  logic              flush,
    output logic              stall,
    output logic              m_ready,
    output logic [DATA_W-1:0] rdata_out,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] bad_addr,
    output logic              data_req,
    output logic              data_wr,
    output logic [2:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [STRB_W-1:0] data_wstrb,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok
);
    state_t            state, nxt;
    logic [3:0]        op, op_r;
    logic              cancel, live, misal, accept, fault;
    logic [DATA_W-1:0] wrep, rext;
    logic [STRB_W-1:0] strb;
    // doubleword ops only exist on a 64-bit bus
    assign op = (DATA_W == 32 && m_op inside {MEMOP_LD, MEMOP_SD, MEMOP_LWU}) ? MEMOP_NONE : m_op;
    mem_align #(.DATA_W(DATA_W)) u_align (
        .op(op), .off(m_addr[OFF_W-1:0]), .wdata(m_wdata),
        .lop(op_r), .loff(data_addr[OFF_W-1:0]), .rdata(data_rdata),
        .misal(misal), .wdata_rep(wrep), .wstrb(strb), .rdata_ext(rext)
    );
    always_comb begin
        live     = state == IDLE && m_valid && op != MEMOP_NONE && !flush;
        accept   = live && !misal;
        fault    = live && misal;
        adel     = fault && is_load(op);
        ades     = fault && is_store(op);
        bad_addr = fault ? m_addr : '0;
        stall    = accept || state == REQ || state == DATA;
        m_ready  = state == DONE;
        data_req = state == REQ;
        nxt      = state;
        case (state)
            IDLE: nxt = accept ? REQ : IDLE;
            REQ:  nxt = data_addr_ok ? DATA : REQ;
            DATA: nxt = data_data_ok ? ((cancel || flush) ? IDLE : DONE) : DATA;
            DONE: nxt = (m_allowin || flush) ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r       <= '0;
            data_addr  <= '0;
            data_size  <= '0;
            data_wr    <= 1'b0;
            data_wdata <= '0;
            data_wstrb <= '0;
            cancel     <= 1'b0;
            rdata_out  <= '0;
        end else begin
            if (accept) begin
                op_r       <= op;
                data_addr  <= m_addr;
                data_size  <= op_size(op);
                data_wr    <= is_store(op);
                data_wdata <= wrep;
                data_wstrb <= strb;
                cancel     <= 1'b0;
            end else if ((state == REQ || state == DATA) && flush) begin
                cancel <= 1'b1;
            end
            if (state == DATA && data_data_ok && !data_wr && !cancel && !flush) rdata_out <= rext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench driving 32- and 64-bit instances of mem_access_unit
module tb_mem_access_unit;
    import mem_pkg::*;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [63:0] wd, rd;
        int          aok, dok;
        bit          fl, rst;
        logic        wr;
        logic [2:0]  sz;
        logic [63:0] ewd;
        logic [7:0]  estrb;
        logic [63:0] erd;
    } tx_t;
    logic clk = 1'b0, rn32, rn64, sel, valid, allowin, flush, aok, dok;
    logic [3:0] op;
    logic [31:0] addr;
    logic [63:0] wdata, rdata;
    logic s32, r32, el32, es32, q32, w32, s64, r64, el64, es64, q64, w64;
    logic [2:0] z32, z64;
    logic [31:0] b32, a32, d32, wd32, b64, a64;
    logic [63:0] d64, wd64;
    logic [3:0] st32;
    logic [7:0] st64;
    logic o_stall, o_ready, o_adel, o_ades, o_req, o_wr;
    logic [2:0] o_size;
    logic [31:0] o_baddr, o_addr;
    logic [63:0] o_rdata, o_wdata;
    logic [7:0] o_strb;
    tx_t q[$];
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    mem_access_unit #(.DATA_W(32)) u32 (
        .clk(clk), .resetn(rn32), .m_valid(valid & !sel), .m_op(op), .m_addr(addr),
        .m_wdata(wdata[31:0]), .m_allowin(allowin), .flush(flush), .stall(s32), .m_ready(r32),
        .rdata_out(d32), .adel(el32), .ades(es32), .bad_addr(b32), .data_req(q32), .data_wr(w32),
        .data_size(z32), .data_addr(a32), .data_wdata(wd32), .data_wstrb(st32),
        .data_addr_ok(aok & !sel), .data_rdata(rdata[31:0]), .data_data_ok(dok & !sel)
    );
    mem_access_unit #(.DATA_W(64)) u64 (
        .clk(clk), .resetn(rn64), .m_valid(valid & sel), .m_op(op), .m_addr(addr),
        .m_wdata(wdata), .m_allowin(allowin), .flush(flush), .stall(s64), .m_ready(r64),
        .rdata_out(d64), .adel(el64), .ades(es64), .bad_addr(b64), .data_req(q64), .data_wr(w64),
        .data_size(z64), .data_addr(a64), .data_wdata(wd64), .data_wstrb(st64),
        .data_addr_ok(aok & sel), .data_rdata(rdata), .data_data_ok(dok & sel)
    );
    always_comb begin
        o_stall = sel ? s64 : s32;
        o_ready = sel ? r64 : r32;
        o_adel  = sel ? el64 : el32;
        o_ades  = sel ? es64 : es32;
        o_req   = sel ? q64 : q32;
        o_wr    = sel ? w64 : w32;
        o_size  = sel ? z64 : z32;
        o_baddr = sel ? b64 : b32;
        o_addr  = sel ? a64 : a32;
        o_rdata = sel ? d64 : {32'h0, d32};
        o_wdata = sel ? wd64 : {32'h0, wd32};
        o_strb  = sel ? st64 : {4'h0, st32};
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask
    task automatic idle_chk(input logic [3:0] o, input logic [31:0] a, input logic v, input logic fl,
                            input logic eel, input logic ees);
        valid = v; op = o; addr = a; flush = fl;
        #1;
        chk("adel", o_adel, eel);
        chk("ades", o_ades, ees);
        chk("bad_addr", o_baddr, (eel | ees) ? a : 32'h0);
        chk("idle_stall", o_stall, 0);
        cyc();
        valid = 0; op = MEMOP_NONE; flush = 0;
        #1;
        chk("idle_req", o_req, 0);
    endtask
    task automatic run(input tx_t t);
        tx_t e;
        q.push_back(t);
        valid = 1; op = t.op; addr = t.addr; wdata = t.wd;
        #1;
        chk("accept_stall", o_stall, 1);
        cyc();
        valid = 0; op = MEMOP_NONE;
        for (int i = 0; i < t.aok; i++) begin
            #1;
            chk("req_hold", o_req, 1);
            chk("req_addr_stable", o_addr, t.addr);
            chk("req_size_stable", o_size, t.sz);
            chk("req_stall", o_stall, 1);
            cyc();
        end
        aok = 1;
        #1;
        e = q.pop_front();
        chk("req", o_req, 1);
        chk("addr", o_addr, e.addr);
        chk("size", o_size, e.sz);
        chk("wr", o_wr, e.wr);
        if (e.wr) begin
            chk("wdata", o_wdata, e.ewd);
            chk("wstrb", o_strb, e.estrb);
        end
        cyc();
        aok = 0;
        for (int i = 0; i < t.dok; i++) begin
            if (i == 0 && t.rst) begin
                if (sel) rn64 = 0; else rn32 = 0;
                #1;
                chk("rst_stall", o_stall, 0);
                chk("rst_req", o_req, 0);
                chk("rst_ready", o_ready, 0);
                chk("rst_addr", o_addr, 0);
                chk("rst_strb", o_strb, 0);
                chk("rst_wdata", o_wdata, 0);
                chk("rst_rdata", o_rdata, 0);
                chk("rst_size", o_size, 0);
                rn32 = 1; rn64 = 1;
                return;
            end
            flush = (i == 0) && t.fl;
            #1;
            chk("data_stall", o_stall, 1);
            chk("data_req_low", o_req, 0);
            cyc();
            flush = 0;
        end
        dok = 1; rdata = t.rd;
        #1;
        chk("dok_stall", o_stall, 1);
        cyc();
        dok = 0;
        if (t.fl) begin
            chk("cancel_ready", o_ready, 0);
            chk("cancel_stall", o_stall, 0);
            chk("cancel_rdata", o_rdata, e.erd);
            cyc();
            chk("cancel_ready2", o_ready, 0);
        end else begin
            chk("ready", o_ready, 1);
            chk("done_stall", o_stall, 0);
            if (!e.wr) chk("rdata", o_rdata, e.erd);
            allowin = 1;
            cyc();
            allowin = 0;
            #1;
            chk("ready_drop", o_ready, 0);
        end
    endtask
    initial begin
        rn32 = 0; rn64 = 0; sel = 0; valid = 0; allowin = 0; flush = 0; aok = 0; dok = 0;
        op = MEMOP_NONE; addr = 0; wdata = 0; rdata = 0;
        cyc();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_stall", o_stall, 0);
            chk("reset_req", o_req, 0);
            chk("reset_ready", o_ready, 0);
            chk("reset_addr", o_addr, 0);
            chk("reset_rdata", o_rdata, 0);
        end
        sel = 0;
        rn32 = 1; rn64 = 1;
        cyc();
        run('{MEMOP_SW,  32'h8000_0004, 64'h1122_3344, 64'h0, 0, 1, 0, 0, 1, SIZE_W, 64'h1122_3344, 8'h0F, 64'h0});
        run('{MEMOP_SB,  32'h8000_0002, 64'hAB, 64'h0, 1, 0, 0, 0, 1, SIZE_B, 64'hABAB_ABAB, 8'h04, 64'h0});
        run('{MEMOP_SH,  32'h8000_0002, 64'hBEEF, 64'h0, 0, 2, 0, 0, 1, SIZE_H, 64'hBEEF_BEEF, 8'h0C, 64'h0});
        run('{MEMOP_LH,  32'h8000_0002, 64'h0, 64'h8001_1234, 0, 1, 0, 0, 0, SIZE_H, 64'h0, 8'h0, 64'hFFFF_8001});
        run('{MEMOP_LBU, 32'h8000_0003, 64'h0, 64'h8001_1234, 2, 0, 0, 0, 0, SIZE_B, 64'h0, 8'h0, 64'h80});
        run('{MEMOP_LB,  32'h8000_0003, 64'h0, 64'h8001_1234, 0, 0, 0, 0, 0, SIZE_B, 64'h0, 8'h0, 64'hFFFF_FF80});
        run('{MEMOP_LW,  32'h8000_0008, 64'h0, 64'h1234_5678, 3, 2, 1, 0, 0, SIZE_W, 64'h0, 8'h0, 64'hFFFF_FF80});
        run('{MEMOP_LW,  32'h8000_000C, 64'h0, 64'hCAFE_F00D, 1, 0, 0, 0, 0, SIZE_W, 64'h0, 8'h0, 64'hCAFE_F00D});
        idle_chk(MEMOP_LW, 32'h8000_0002, 1, 0, 1, 0);
        idle_chk(MEMOP_SH, 32'h8000_0001, 1, 0, 0, 1);
        idle_chk(MEMOP_SW, 32'h8000_0003, 1, 0, 0, 1);
        idle_chk(MEMOP_LH, 32'h8000_0001, 1, 1, 0, 0);
        idle_chk(MEMOP_LW, 32'h8000_0001, 0, 0, 0, 0);
        idle_chk(MEMOP_LD, 32'h8000_0008, 1, 0, 0, 0);
        idle_chk(MEMOP_SW, 32'h8000_0000, 1, 1, 0, 0);
        sel = 1;
        run('{MEMOP_LD,  32'h8000_0008, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 1, 0, 0, 0, SIZE_D, 64'h0, 8'h0, 64'hFEDC_BA98_7654_3210});
        run('{MEMOP_SW,  32'h8000_0004, 64'h1122_3344, 64'h0, 1, 1, 0, 0, 1, SIZE_W, 64'h1122_3344_1122_3344, 8'hF0, 64'h0});
        run('{MEMOP_SD,  32'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0, 0, 1, SIZE_D, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0});
        run('{MEMOP_SB,  32'h8000_0005, 64'h5A, 64'h0, 0, 0, 0, 0, 1, SIZE_B, 64'h5A5A_5A5A_5A5A_5A5A, 8'h20, 64'h0});
        run('{MEMOP_LW,  32'h8000_0004, 64'h0, 64'h8000_0000_1234_5678, 0, 1, 0, 0, 0, SIZE_W, 64'h0, 8'h0, 64'hFFFF_FFFF_8000_0000});
        run('{MEMOP_LWU, 32'h8000_0004, 64'h0, 64'h8000_0000_1234_5678, 0, 1, 0, 0, 0, SIZE_W, 64'h0, 8'h0, 64'h0000_0000_8000_0000});
        idle_chk(MEMOP_LD, 32'h8000_0004, 1, 0, 1, 0);
        idle_chk(MEMOP_SD, 32'h8000_0002, 1, 0, 0, 1);
        run('{MEMOP_LD,  32'h8000_0018, 64'h0, 64'h0, 1, 2, 0, 1, 0, SIZE_D, 64'h0, 8'h0, 64'h0});
        cyc();
        #1;
        chk("post_reset_stall", o_stall, 0);
        chk("post_reset_ready", o_ready, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
